fetch_unit: RTL

//  Fetch stage that produces instr/pcplus4 for the F/D pipeline register and obeys its redo (stall).

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs a single-outstanding req/ack fetch to imem,
// and feeds the F/D register with a one-entry skid for stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redo,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        armed;
    logic [31:0] pc, pc_n;
    logic [31:0] drain_addr, drain_addr_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic [31:0] instr_n, pc4_n;
    logic        valid_n;
    logic [31:0] pc_inc;
    logic [31:0] tgt;
    logic        ack;

    // armed delays the first request by one cycle after reset release
    assign imem_req  = armed && (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign ack       = imem_req && imem_ack;
    assign pc_inc    = pc + 32'd4;
    assign tgt       = {branch_target[31:2], 2'b00};

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        instr_n      = instr_o;
        pc4_n        = pcplus4_o;
        valid_n      = instr_valid;
        unique case (state)
            ISSUE: begin
                if (branch_taken) begin
                    pc_n    = tgt;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                    if (imem_req && !imem_ack) begin
                        state_n      = DRAIN;
                        drain_addr_n = pc;
                    end
                end else if (ack) begin
                    pc_n = pc_inc;
                    if (redo) begin
                        skid_instr_n = imem_rdata;
                        skid_pc4_n   = pc_inc;
                        state_n      = HOLD;
                    end else begin
                        instr_n = imem_rdata;
                        pc4_n   = pc_inc;
                        valid_n = 1'b1;
                    end
                end else if (!redo) begin
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_n    = tgt;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                    state_n = ISSUE;
                end else if (!redo) begin
                    instr_n = skid_instr;
                    pc4_n   = skid_pc4;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pc_n    = tgt;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                end
                if (imem_ack) begin
                    state_n = ISSUE;
                end
            end
            default: begin
                state_n = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ISSUE;
            armed       <= 1'b0;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            skid_instr  <= NOP_INSTR;
            skid_pc4    <= 32'd0;
            instr_o     <= NOP_INSTR;
            pcplus4_o   <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            armed       <= 1'b1;
            pc          <= pc_n;
            drain_addr  <= drain_addr_n;
            skid_instr  <= skid_instr_n;
            skid_pc4    <= skid_pc4_n;
            instr_o     <= instr_n;
            pcplus4_o   <= pc4_n;
            instr_valid <= valid_n;
        end
    end

endmodule
